// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB completer slice.
// `AW / `DW may be predefined to change the default bus widths.
`ifndef AW
`define AW 8
`endif
`ifndef DW
`define DW 8
`endif

package apb_pkg;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} apb_cmp_state_e;

    localparam int AW_DEFAULT = `AW;
    localparam int DW_DEFAULT = `DW;

    // Wait counter must hold WAIT_STATES; a zero-wait build still needs one bit.
    function automatic int cnt_width(input int ws);
        int w;
        w = $clog2(ws + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_completer_regfile.sv
// DEPTH x DW register file: async clear, one write port, one registered read port.
// rd_clr loads zero instead of array data (used for error responses).
module apb_completer_regfile #(
    parameter int DW    = 8,
    parameter int DEPTH = 64,
    parameter int IW    = 6
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          rd_clr,
    input  logic [IW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_clr ? '0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/apb_completer.sv
// APB completer with fixed wait states in front of a local register file.
// Define APB_SLVERR_EN to answer out-of-range addresses with pslverr instead of aliasing.
module apb_completer
    import apb_pkg::*;
#(
    parameter int AW          = AW_DEFAULT,
    parameter int DW          = DW_DEFAULT,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic          pready,
    output logic [DW-1:0] prdata,
    output logic          pslverr
);

    localparam int CW = cnt_width(WAIT_STATES);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    apb_cmp_state_e state;
    logic [CW-1:0]  cnt;
    logic           err_q;
    logic           addr_err;
    logic           setup;
    logic           ready_cyc;
    logic           complete;
    logic           enter_ready;

    assign setup     = (state == IDLE) && psel && !penable;
    assign ready_cyc = (state == ACCESS) && (cnt == '0);
    assign complete  = ready_cyc && psel && penable;
    // Read data is fetched on the edge into the ready cycle so it is valid with pready.
    assign enter_ready = (setup && (WAIT_STATES == 0)) ||
                         ((state == ACCESS) && psel && (cnt == CNT_ONE));
    assign pready    = ready_cyc;

`ifdef APB_SLVERR_EN
    assign addr_err = ({1'b0, paddr} >= (AW + 1)'(DEPTH));
    assign pslverr  = ready_cyc & err_q;
`else
    logic unused_paddr;
    assign unused_paddr = ^paddr;
    assign addr_err = 1'b0;
    assign pslverr  = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        state <= ACCESS;
                        cnt   <= CNT_LOAD;
                        err_q <= addr_err;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state <= IDLE;
                        cnt   <= '0;
                        err_q <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (penable) begin
                        state <= IDLE;
                        err_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    apb_completer_regfile #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_regfile (
        .pclk    (pclk),
        .presetn (presetn),
        .wr_en   (complete && pwrite && !err_q),
        .wr_addr (paddr[IW-1:0]),
        .wr_data (pwdata),
        .rd_en   (enter_ready && !pwrite),
        .rd_clr  (addr_err),
        .rd_addr (paddr[IW-1:0]),
        .rd_data (prdata)
    );

endmodule
